// File: rtl/cordic_fixed_to_float.sv
// Exact signed Q(INTEGER_WIDTH).(FRACTIONAL_WIDTH) to IEEE-754 single conversion.
// Three clk_en-gated stages: sign/magnitude, normalise, pack; squared float rides alongside.
module cordic_fixed_to_float #(
    parameter int unsigned INTEGER_WIDTH    = 2,
    parameter int unsigned FRACTIONAL_WIDTH = 20,
    parameter int unsigned DATA_WIDTH       = INTEGER_WIDTH + FRACTIONAL_WIDTH,
    parameter int unsigned FLOAT_DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_en,
    input  logic [DATA_WIDTH-1:0]       fixed_in,
    input  logic [FLOAT_DATA_WIDTH-1:0] squared_in,
    input  logic                        valid_in,
    output logic [FLOAT_DATA_WIDTH-1:0] float_out,
    output logic [FLOAT_DATA_WIDTH-1:0] squared_out,
    output logic                        valid_out,
    output logic                        pipeline_cleared
);

    localparam int unsigned LZ_W     = $clog2(DATA_WIDTH);
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MANT_W   = 23;
    localparam int unsigned MANT_PAD = MANT_W - (DATA_WIDTH - 1);
    localparam int unsigned EXP_TOP  = 127 + INTEGER_WIDTH - 1;

    logic                        r_s1_sign, r_s1_zero, r_s1_vld;
    logic [DATA_WIDTH-1:0]       r_s1_mag;
    logic [FLOAT_DATA_WIDTH-1:0] r_s1_sq;

    logic                        r_s2_sign, r_s2_zero, r_s2_vld;
    logic [DATA_WIDTH-1:0]       r_s2_norm;
    logic [LZ_W-1:0]             r_s2_lz;
    logic [FLOAT_DATA_WIDTH-1:0] r_s2_sq;

    logic [FLOAT_DATA_WIDTH-1:0] r_float, r_sq;
    logic                        r_vld;

    logic [DATA_WIDTH-1:0]       w_mag;
    logic [LZ_W-1:0]             w_lz;
    logic [EXP_W-1:0]            w_exp;
    logic [FLOAT_DATA_WIDTH-1:0] w_float;

    // The most negative input has a magnitude that still fits unsigned in DATA_WIDTH bits.
    always_comb begin
        w_mag = fixed_in[DATA_WIDTH-1] ? (~fixed_in + DATA_WIDTH'(1)) : fixed_in;
    end

    // Leading-zero count: the highest set bit is visited last and wins.
    always_comb begin
        w_lz = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (r_s1_mag[i]) begin
                w_lz = LZ_W'(DATA_WIDTH - 1 - i);
            end
        end
    end

    always_comb begin
        w_exp   = EXP_W'(EXP_TOP) - EXP_W'(r_s2_lz);
        w_float = FLOAT_DATA_WIDTH'({r_s2_sign, w_exp, r_s2_norm[DATA_WIDTH-2:0], MANT_PAD'(0)});
        if (r_s2_zero) begin
            w_float = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_sign <= 1'b0;
            r_s1_zero <= 1'b0;
            r_s1_vld  <= 1'b0;
            r_s1_mag  <= '0;
            r_s1_sq   <= '0;
            r_s2_sign <= 1'b0;
            r_s2_zero <= 1'b0;
            r_s2_vld  <= 1'b0;
            r_s2_norm <= '0;
            r_s2_lz   <= '0;
            r_s2_sq   <= '0;
            r_float   <= '0;
            r_sq      <= '0;
            r_vld     <= 1'b0;
        end else if (clk_en) begin
            r_s1_sign <= fixed_in[DATA_WIDTH-1];
            r_s1_zero <= (fixed_in == '0);
            r_s1_vld  <= valid_in;
            r_s1_mag  <= w_mag;
            r_s1_sq   <= squared_in;
            r_s2_sign <= r_s1_sign;
            r_s2_zero <= r_s1_zero;
            r_s2_vld  <= r_s1_vld;
            r_s2_norm <= r_s1_mag << w_lz;
            r_s2_lz   <= w_lz;
            r_s2_sq   <= r_s1_sq;
            r_float   <= w_float;
            r_sq      <= r_s2_sq;
            r_vld     <= r_s2_vld;
        end
    end

    assign float_out        = r_float;
    assign squared_out      = r_sq;
    assign valid_out        = r_vld;
    assign pipeline_cleared = ~(r_s1_vld | r_s2_vld | r_vld);

endmodule
